// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// fwd_hazard_ctrl : EX-stage operand forwarding and load-use/memory interlock
// Revision 1.0
// ============================================================================
module fwd_hazard_ctrl #(
    parameter int RA_W       = 5,
    parameter int LOAD_STALL = 1,
    parameter int FWD_R0     = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  ifid_rs,
    input  logic [RA_W-1:0]  ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic [RA_W-1:0]  idex_rs,
    input  logic [RA_W-1:0]  idex_rt,
    input  logic [RA_W-1:0]  idex_dst,
    input  logic             idex_regwrite,
    input  logic             idex_memread,
    input  logic             idex_memwrite,
    input  logic             exmem_regwrite,
    input  logic [RA_W-1:0]  exmem_dst,
    input  logic             exmem_memreq,
    input  logic             dmem_ready,
    input  logic             memwb_regwrite,
    input  logic [RA_W-1:0]  memwb_dst,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [0:0] S_RUN      = 1'b0;
    localparam logic [0:0] S_LU_STALL = 1'b1;
    localparam logic [2:0] C_LU_INIT  = 3'(LOAD_STALL - 1);

    logic [0:0]       r_state, w_state_nxt;
    logic [2:0]       r_lu_cnt, w_lu_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_mem_stall;
    logic             w_lu_haz;

    function automatic logic qual_match(input logic we, input logic [RA_W-1:0] dst,
                                        input logic [RA_W-1:0] src);
        return we && ((dst != '0) || (FWD_R0 != 0)) && (dst == src);
    endfunction

    assign w_mem_stall = exmem_memreq & ~dmem_ready;
    assign w_lu_haz    = (r_state == S_RUN) && idex_memread &&
                         (qual_match(idex_regwrite, idex_dst, ifid_rs) ||
                          (ifid_uses_rt && qual_match(idex_regwrite, idex_dst, ifid_rt)));

    // EX/MEM always wins over MEM/WB; code 11 routes EX/MEM onto store data only
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (rst) begin
            if (qual_match(exmem_regwrite, exmem_dst, idex_rs))
                fwd_a = 2'b10;
            else if (qual_match(memwb_regwrite, memwb_dst, idex_rs))
                fwd_a = 2'b01;

            if (qual_match(exmem_regwrite, exmem_dst, idex_rt))
                fwd_b = (idex_memwrite && !idex_regwrite) ? 2'b11 : 2'b10;
            else if (qual_match(memwb_regwrite, memwb_dst, idex_rt))
                fwd_b = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_RUN;
            r_lu_cnt <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_lu_cnt <= w_lu_cnt_nxt;
        end
    end

    // A memory freeze holds the bubble schedule so the total stays LOAD_STALL
    always_comb begin
        w_state_nxt  = r_state;
        w_lu_cnt_nxt = r_lu_cnt;
        if (!w_mem_stall) begin
            case (r_state)
                S_RUN: begin
                    if (w_lu_haz && (LOAD_STALL > 1)) begin
                        w_state_nxt  = S_LU_STALL;
                        w_lu_cnt_nxt = C_LU_INIT;
                    end
                end
                S_LU_STALL: begin
                    w_lu_cnt_nxt = r_lu_cnt - 3'd1;
                    if (r_lu_cnt == 3'd1)
                        w_state_nxt = S_RUN;
                end
                default: w_state_nxt = S_RUN;
            endcase
        end
    end

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        idex_bubble = 1'b1;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        if (rst) begin
            if (w_mem_stall) begin
                idex_bubble = 1'b0;
            end else if ((r_state == S_LU_STALL) || w_lu_haz) begin
                idex_en     = 1'b1;
                idex_bubble = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
            end else begin
                pc_en       = 1'b1;
                ifid_en     = 1'b1;
                idex_en     = 1'b1;
                idex_bubble = 1'b0;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_cnt <= '0;
        else if (!pc_en && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
